pipe_fifo: RTL and testbench
============================

Name: pipe_fifo

Overview:
Single-clock 16-bit synchronous FIFO that buffers a sample stream for block transfer over a host pipe. It provides full, almost_full, empty and a programmable-full flag. The flag marks that a 1024-word block is available to read. The upstream block-read controller drains it in 1024-word bursts and uses almost_full to drop the oldest data before overflow.

Parameters:
DATA_W, 16, data word width
DEPTH, 2048, number of storage words; must be a power of two
PROG_FULL_THRESH, 1024, occupancy at or above which prog_full asserts

Ports:
clk  input  1  single clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
din  input  DATA_W  write data
wr_en  input  1  write request
rd_en  input  1  read request
dout  output  DATA_W  read data, registered
full  output  1  occupancy == DEPTH
almost_full  output  1  occupancy >= DEPTH-1
prog_full  output  1  occupancy >= PROG_FULL_THRESH
empty  output  1  occupancy == 0

Behaviour:
- Reset (asynchronous assert, applies immediately; released synchronously to clk):
  - occupancy counter and read/write pointers = 0
  - empty=1; full=0, almost_full=0, prog_full=0; dout=0
  - stored contents are don't-care
  - reset mid-operation discards all data.
- Write acceptance: wr_acc = wr_en & ~full.
  - Accepted write stores din at wr_ptr; wr_ptr increments mod DEPTH.
  - Write while full is ignored: no data or pointer change.
- Read acceptance: rd_acc = rd_en & ~empty.
  - Standard (non-first-word-fall-through) read.
  - dout loads mem[rd_ptr] on the edge where rd_acc=1, so the word is visible one cycle after rd_en; rd_ptr increments mod DEPTH.
  - Read while empty is ignored: dout holds its previous value.
- dout holds its value whenever no read is accepted.
- Occupancy counter is log2(DEPTH)+1 bits wide and changes by +1 on a write only, -1 on a read only, and 0 when both or neither are accepted.
- Simultaneous wr_en and rd_en:
  - When empty: only the write is accepted; count goes 0 -> 1.
  - When full: only the read is accepted; count goes DEPTH -> DEPTH-1.
  - Otherwise both are accepted and count is unchanged.
- Flags decode combinationally from the registered count, so they reflect an operation one cycle after its accepting edge. No glitching paths from wr_en/rd_en to the flags.
- Pointer wrap-around is seamless; data order is strictly FIFO across the wrap.
- Memory is a simple dual-port array, one write port and one registered read port, inferable as block RAM. No reset on the array.

Decomposition:
- Shared package pipe_pkg holds PIPE_DATA_W=16, PIPE_FIFO_DEPTH=2048, PIPE_BLOCK_LEN=1024; parameter defaults are taken from it.
- One sub-module, pipe_fifo_ram: DATA_W x DEPTH simple dual-port RAM with ports clk, we, waddr, wdata, re, raddr, rdata (rdata registered).
- Pointer, count and flag logic stays in pipe_fifo.

Test Plan:
- Reset: assert rst mid-stream after 10 writes. Outputs immediately show empty=1, full=0, almost_full=0, prog_full=0, dout=0; a subsequent read with rd_en=1 leaves dout=0.
- Ordered data: write 0x0000..0x0009, then pulse rd_en 10 cycles. dout shows 0x0000..0x0009 in order, each one cycle after its rd_en; empty rises the cycle after the 10th read.
- prog_full: write 1023 words, prog_full=0; the 1024th write raises it the following cycle. One read drops it back to 0.
- Full/almost_full: write 2047 words, almost_full=1 and full=0. The 2048th write gives full=1. A 2049th write with din=0xDEAD is dropped; reading all 2048 words returns the original sequence with no 0xDEAD.
- Simultaneous edge cases:
  - wr_en=rd_en=1 while empty: count becomes 1 and dout does not change.
  - wr_en=rd_en=1 while full: full deasserts and the oldest word appears on dout.
  - wr_en=rd_en=1 at mid-occupancy 500: occupancy stays 500 over 100 cycles.
- Wrap-around: stream 5000 incrementing words, reading concurrently at occupancy about 1000. Every dout value equals the expected counter, with no gaps or duplicates across pointer wraps.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the host-pipe sample buffer.
// Parameter defaults for pipe_fifo and its RAM are taken from here.
package pipe_pkg;

   localparam int unsigned PIPE_DATA_W     = 16;
   localparam int unsigned PIPE_FIFO_DEPTH = 2048;
   localparam int unsigned PIPE_BLOCK_LEN  = 1024;

   // True when n is a non-zero power of two.
   function automatic bit pipe_is_pow2(input int unsigned n);
      return (n != 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/pipe_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset on the array or on rdata so it maps onto block RAM.
module pipe_fifo_ram
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = PIPE_DATA_W,
   parameter int unsigned DEPTH  = PIPE_FIFO_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= r_mem[raddr];
      end
   end

endmodule

// File: rtl/pipe_fifo.sv
// Single-clock FIFO buffering a sample stream for block transfer over a host pipe.
// Standard (non-FWFT) read: dout updates on the edge that accepts rd_en.
module pipe_fifo
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W           = PIPE_DATA_W,
   parameter int unsigned DEPTH            = PIPE_FIFO_DEPTH,
   parameter int unsigned PROG_FULL_THRESH = PIPE_BLOCK_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              wr_en,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              almost_full,
   output logic              prog_full,
   output logic              empty
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_count_nxt;
   logic              r_dout_vld;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [DATA_W-1:0] w_ram_rdata;

   assign w_wr_acc = wr_en & ~full;
   assign w_rd_acc = rd_en & ~empty;

   // Flags come only from the registered count, never from wr_en/rd_en.
   assign full        = (r_count == CNT_W'(DEPTH));
   assign almost_full = (r_count >= CNT_W'(DEPTH - 1));
   assign prog_full   = (r_count >= CNT_W'(PROG_FULL_THRESH));
   assign empty       = (r_count == '0);

   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_dout_vld <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
            r_dout_vld <= 1'b1;
         end
      end
   end

   // The RAM output register has no reset; mask it to zero until the first
   // read after reset so dout still clears asynchronously.
   assign dout = r_dout_vld ? w_ram_rdata : '0;

   // Pointers only coincide when empty or full, so a read and a write never
   // target the same address in one cycle.
   pipe_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (w_wr_acc),
      .waddr (r_wr_ptr),
      .wdata (din),
      .re    (w_rd_acc),
      .raddr (r_rd_ptr),
      .rdata (w_ram_rdata)
   );

endmodule

// File: tb/tb_pipe_fifo.sv
// Scoreboard bench for pipe_fifo: a queue model predicts read data and flags,
// and a negedge monitor compares the DUT against it every cycle.
module tb_pipe_fifo;
   import pipe_pkg::*;

   localparam int DW    = PIPE_DATA_W;
   localparam int DEPTH = PIPE_FIFO_DEPTH;
   localparam int THR   = PIPE_BLOCK_LEN;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          full, almost_full, prog_full, empty;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] model_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_dout = '0;

   pipe_fifo dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .dout        (dout),
      .full        (full),
      .almost_full (almost_full),
      .prog_full   (prog_full),
      .empty       (empty)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // One clock of stimulus; acceptance follows the FIFO rules on the model's occupancy.
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                       output logic wa, output logic ra);
      int occ;
      occ = model_q.size();
      wr_en = w;
      rd_en = r;
      din   = d;
      wa = w && (occ != DEPTH);
      ra = r && (occ != 0);
      @(posedge clk);
      #1;
      if (ra) exp_q.push_back(model_q.pop_front());
      if (wa) model_q.push_back(d);
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic wr(input logic [DW-1:0] d);
      logic wa, ra;
      step(1'b1, 1'b0, d, wa, ra);
   endtask

   task automatic rd();
      logic wa, ra;
      step(1'b0, 1'b1, '0, wa, ra);
   endtask

   task automatic both(input logic [DW-1:0] d);
      logic wa, ra;
      step(1'b1, 1'b1, d, wa, ra);
   endtask

   task automatic idle(input int n);
      logic wa, ra;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, wa, ra);
   endtask

   task automatic drain();
      while (model_q.size() > 0) rd();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_empty"}, empty, 1);
      check({tag, "_full"}, full, 0);
      check({tag, "_almost_full"}, almost_full, 0);
      check({tag, "_prog_full"}, prog_full, 0);
      check({tag, "_dout"}, dout, 0);
   endtask

   // Called just after a posedge; reset lands mid-cycle and is released after the next edge.
   task automatic mid_reset();
      #2;
      rst = 1'b1;
      model_q.delete();
      exp_q.delete();
      last_dout = '0;
      #1;
      check_reset_outputs("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      int occ;
      logic [DW-1:0] e;
      occ = model_q.size();
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("dout", dout, e);
         last_dout = e;
      end else begin
         check("dout_hold", dout, last_dout);
      end
      check("empty", empty, occ == 0);
      check("full", full, occ == DEPTH);
      check("almost_full", almost_full, occ >= DEPTH - 1);
      check("prog_full", prog_full, occ >= THR);
   end

   initial begin
      int written;
      int cyc;
      logic wa, ra, w, r;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst = 1'b0;

      // Reset in the middle of a stream, then a read against the emptied FIFO.
      for (int i = 0; i < 10; i++) wr(DW'($urandom));
      mid_reset();
      rd();
      idle(2);

      // Ordered data.
      for (int i = 0; i < 10; i++) wr(DW'(i));
      for (int i = 0; i < 10; i++) rd();
      idle(2);

      // Programmable-full threshold.
      for (int i = 0; i < THR - 1; i++) wr(DW'($urandom));
      idle(1);
      check("prog_full_below", prog_full, 0);
      wr(DW'($urandom));
      idle(1);
      check("prog_full_at", prog_full, 1);
      rd();
      idle(1);
      check("prog_full_after_rd", prog_full, 0);
      drain();
      idle(2);

      // Full / almost_full and a dropped write while full.
      for (int i = 0; i < DEPTH - 1; i++) wr(DW'(i));
      idle(1);
      check("af_at_depth_m1", almost_full, 1);
      check("full_at_depth_m1", full, 0);
      wr(DW'(DEPTH - 1));
      wr(16'hDEAD);
      idle(1);
      check("full_at_depth", full, 1);
      drain();
      idle(2);

      // Simultaneous read/write while full: only the read is taken.
      for (int i = 0; i < DEPTH; i++) wr(DW'($urandom));
      both(16'hBEEF);
      idle(1);
      check("full_after_both", full, 0);
      drain();
      idle(2);

      // Simultaneous read/write while empty: only the write is taken.
      both(16'h1234);
      idle(1);
      check("empty_after_both", empty, 0);
      drain();
      idle(2);

      // Balanced traffic at occupancy 500.
      for (int i = 0; i < 500; i++) wr(DW'($urandom));
      for (int i = 0; i < 100; i++) both(DW'($urandom));
      drain();
      idle(2);

      // Wrap-around: 5000 incrementing words, reading once about 1000 are held.
      written = 0;
      cyc = 0;
      while (written < 5000 && cyc < 20000) begin
         w = ($urandom % 8) != 0;
         r = (model_q.size() >= 1000) && (($urandom % 8) != 0);
         step(w, r, DW'(written), wa, ra);
         if (wa) written++;
         cyc++;
      end
      if (written < 5000) begin
         n_bad++;
         $display("FAIL wrap_budget: wrote %0d words, required 5000", written);
      end
      drain();
      idle(2);

      // Free-running random traffic.
      for (int i = 0; i < 3000; i++) begin
         w = ($urandom % 2) != 0;
         r = ($urandom % 2) != 0;
         step(w, r, DW'($urandom), wa, ra);
      end
      drain();
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
